// File: rtl/riscv_enc_pkg.sv
// RV32I encoder shared types: format enum, opcode constants, immediate limits
// and the pure field-to-word encoder used by inst_encoder.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic        legal;
        logic [31:0] inst;
    } enc_t;

    // Scatter the immediate per format; an illegal bundle yields an all-zero word.
    function automatic enc_t encode_fields(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_t              res;
        logic signed [31:0] simm;
        res  = '0;
        simm = signed'(imm);
        case (fmt)
            FMT_R: begin
                res.legal = 1'b1;
                res.inst  = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                res.legal = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
                res.inst  = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: begin
                res.legal = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
                res.inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            FMT_B: begin
                res.legal = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
                res.inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            FMT_U: begin
                res.legal = (imm[11:0] == 12'd0);
                res.inst  = {imm[31:12], rd, opcode};
            end
            FMT_J: begin
                res.legal = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && !imm[0];
                res.inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: res = '0;
        endcase
        if (!res.legal) begin
            res.inst = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output bus of the instruction encoder.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              imm_err;
    logic [ADDR_W-1:0] wr_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, imm_err, wr_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, imm_err, wr_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push && !full_c;
    assign do_pop_c  = pop && !empty_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push_c && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign rd_data_c = empty_c ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_encoder.sv
// RV32I field encoder: encodes accepted bundles, buffers legal words and drains
// them to instruction memory at an auto-incrementing word address.
module inst_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    inst_encoder_if.slave bus
);
    enc_t              enc_c;
    logic              ready_c;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              empty_c;
    logic [31:0]       head_c;
    logic              run_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;

    always_comb begin
        enc_c = encode_fields(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1,
                              bus.in_rs2, bus.in_funct3, bus.in_funct7, bus.in_imm);
    end

    // run_q keeps in_ready low for the cycle following a reset edge.
    assign ready_c  = run_q && !full_c;
    assign accept_c = bus.in_valid && ready_c;
    assign push_c   = accept_c && enc_c.legal;
    assign pop_c    = !empty_c && bus.out_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .wr_data   (enc_c.inst),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Rejected bundles pulse imm_err and never consume an address.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            run_q <= 1'b1;
            err_q <= accept_c && !enc_c.legal;
            if (pop_c) begin
                addr_q  <= addr_q + ADDR_W'(1);
                count_q <= count_q + ADDR_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = !empty_c;
    assign bus.out_inst  = head_c;
    assign bus.out_addr  = addr_q;
    assign bus.imm_err   = err_q;
    assign bus.wr_count  = count_q;

endmodule
